fifo_rptr_empty: RTL and testbench

// Read-side control for the 8x8 async FIFO; sits entirely in the r_clk domain opposite the write-side control.

---
 rtl/fifo_pkg.sv | 26 ++
 rtl/ptr_sync.sv | 31 +++
 rtl/fifo_rptr_empty.sv | 76 +++++++
 tb/tb_fifo_rptr_empty.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and pointer-code helpers for the 8x8 async FIFO.
// Helpers work on zero-extended 32-bit values, so any pointer width up to 32 bits can use them.
package fifo_pkg;

    localparam int FIFO_ADDR_W = 3;
    localparam int FIFO_DATA_W = 8;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        logic [31:0] g;
        for (int i = 0; i < 31; i++) begin
            g[i] = b[i] ^ b[i+1];
        end
        g[31] = b[31];
        return g;
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/ptr_sync.sv
// N-stage, W-bit flop synchroniser for a Gray-coded pointer crossing clock domains.
// Latency: N clk edges from d to q.
// Backpressure: none; samples every edge.
module ptr_sync #(
    parameter int W = 4,
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stg [N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                stg[i] <= '0;
            end
        end else begin
            stg[0] <= d;
            for (int i = 1; i < N; i++) begin
                stg[i] <= stg[i-1];
            end
        end
    end

    assign q = stg[N-1];

endmodule

// File: rtl/fifo_rptr_empty.sv
// Read-side pointer, empty/almost-empty flags and fill level for the async FIFO.
// Latency: flags follow a read on the next edge; writes show up SYNC_STAGES+1 edges later.
// Backpressure: reads while empty are dropped and latch r_underflow.
module fifo_rptr_empty
    import fifo_pkg::*;
#(
    parameter int ADDR_W      = FIFO_ADDR_W,
    parameter int SYNC_STAGES = 2,
    parameter int AE_THRESH   = 1
) (
    input  logic              r_clk,
    input  logic              r_rst_n,
    input  logic              r_en,
    input  logic [ADDR_W:0]   w_ptr_gray,
    output logic [ADDR_W-1:0] r_addr,
    output logic [ADDR_W:0]   r_ptr_gray,
    output logic              r_empty,
    output logic              r_almost_empty,
    output logic [ADDR_W:0]   r_level,
    output logic              r_valid,
    output logic              r_underflow
);

    localparam int            PW     = ADDR_W + 1;
    localparam logic [PW-1:0] AE_LVL = PW'(AE_THRESH);

    logic [PW-1:0] r_bin;
    logic [PW-1:0] r_bin_next;
    logic [PW-1:0] r_gray_next;
    logic [PW-1:0] wq_gray;
    logic [PW-1:0] wq_bin;
    logic [PW-1:0] level_next;
    logic          r_inc;

    ptr_sync #(
        .W (PW),
        .N (SYNC_STAGES)
    ) u_wptr_sync (
        .clk   (r_clk),
        .rst_n (r_rst_n),
        .d     (w_ptr_gray),
        .q     (wq_gray)
    );

    // Flags are judged on the post-read pointer so the last word drains without a bubble.
    always_comb begin
        r_inc       = r_en & ~r_empty;
        r_bin_next  = r_bin + {{ADDR_W{1'b0}}, r_inc};
        r_gray_next = PW'(bin2gray(32'(r_bin_next)));
        wq_bin      = PW'(gray2bin(32'(wq_gray)));
        level_next  = wq_bin - r_bin_next;
    end

    always_ff @(posedge r_clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            r_bin          <= '0;
            r_ptr_gray     <= '0;
            r_empty        <= 1'b1;
            r_almost_empty <= 1'b1;
            r_level        <= '0;
            r_valid        <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            r_bin          <= r_bin_next;
            r_ptr_gray     <= r_gray_next;
            r_empty        <= (r_gray_next == wq_gray);
            r_almost_empty <= (level_next <= AE_LVL);
            r_level        <= level_next;
            r_valid        <= r_inc;
            r_underflow    <= r_underflow | (r_en & r_empty);
        end
    end

    assign r_addr = r_bin[ADDR_W-1:0];

endmodule

// File: tb/tb_fifo_rptr_empty.sv
// Directed table, hand-written corner sequences and a randomized run against a counting model.
module tb_fifo_rptr_empty;

    logic       r_clk = 1'b0;
    logic       r_rst_n = 1'b0;
    logic       r_en = 1'b0;
    logic [3:0] w_ptr_gray = 4'd0;
    logic [2:0] r_addr;
    logic [3:0] r_ptr_gray;
    logic       r_empty;
    logic       r_almost_empty;
    logic [3:0] r_level;
    logic       r_valid;
    logic       r_underflow;

    int checks = 0;
    int errors = 0;

    fifo_rptr_empty dut (
        .r_clk          (r_clk),
        .r_rst_n        (r_rst_n),
        .r_en           (r_en),
        .w_ptr_gray     (w_ptr_gray),
        .r_addr         (r_addr),
        .r_ptr_gray     (r_ptr_gray),
        .r_empty        (r_empty),
        .r_almost_empty (r_almost_empty),
        .r_level        (r_level),
        .r_valid        (r_valid),
        .r_underflow    (r_underflow)
    );

    always #5 r_clk = ~r_clk;

    typedef struct {
        logic       en;
        logic [3:0] wg;
        logic       empty;
        logic       ae;
        logic [3:0] lvl;
        logic [2:0] addr;
        logic [3:0] pg;
        logic       valid;
        logic       uf;
    } vec_t;

    vec_t tbl [9];

    function automatic logic [3:0] g4(input int v);
        logic [3:0] t;
        t = 4'(v);
        return t ^ (t >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic empty, input logic ae, input logic [3:0] lvl,
                           input logic [2:0] addr, input logic [3:0] pg, input logic valid, input logic uf);
        chk({tag, ".empty"}, 32'(r_empty), 32'(empty));
        chk({tag, ".ae"},    32'(r_almost_empty), 32'(ae));
        chk({tag, ".level"}, 32'(r_level), 32'(lvl));
        chk({tag, ".addr"},  32'(r_addr), 32'(addr));
        chk({tag, ".pgray"}, 32'(r_ptr_gray), 32'(pg));
        chk({tag, ".valid"}, 32'(r_valid), 32'(valid));
        chk({tag, ".uflow"}, 32'(r_underflow), 32'(uf));
    endtask

    task automatic tick();
        @(posedge r_clk);
        #1;
    endtask

    task automatic do_reset();
        r_en       = 1'b0;
        w_ptr_gray = 4'd0;
        r_rst_n    = 1'b0;
        tick();
        tick();
        r_rst_n    = 1'b1;
    endtask

    // Counting reference: reads and writes as plain integers, with the write count
    // seen two edges late and level = seen writes minus reads.
    int m_w, m_rd, m_uf;
    bit m_empty;
    int m_seen_q[$];

    task automatic model_reset();
        m_w = 0; m_rd = 0; m_uf = 0; m_empty = 1'b1;
        m_seen_q = {};
        m_seen_q.push_back(0);
        m_seen_q.push_back(0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int seen, lvl;
        bit acc;
        // en, w_gray, empty, ae, level, addr, pgray, valid, underflow
        tbl[0] = '{1'b0, 4'b0001, 1'b1, 1'b1, 4'd0, 3'd0, 4'b0000, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 4'b0001, 1'b1, 1'b1, 4'd0, 3'd0, 4'b0000, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 4'b0001, 1'b0, 1'b1, 4'd1, 3'd0, 4'b0000, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 4'b0001, 1'b1, 1'b1, 4'd0, 3'd1, 4'b0001, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 4'b0001, 1'b1, 1'b1, 4'd0, 3'd1, 4'b0001, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 4'b0001, 1'b1, 1'b1, 4'd0, 3'd1, 4'b0001, 1'b0, 1'b1};
        tbl[6] = '{1'b1, 4'b0001, 1'b1, 1'b1, 4'd0, 3'd1, 4'b0001, 1'b0, 1'b1};
        tbl[7] = '{1'b1, 4'b0001, 1'b1, 1'b1, 4'd0, 3'd1, 4'b0001, 1'b0, 1'b1};
        tbl[8] = '{1'b0, 4'b0001, 1'b1, 1'b1, 4'd0, 3'd1, 4'b0001, 1'b0, 1'b1};

        // Reset values
        tick();
        chk_all("reset", 1'b1, 1'b1, 4'd0, 3'd0, 4'd0, 1'b0, 1'b0);
        r_rst_n = 1'b1;
        tick();

        // First write, single read, reads while empty
        for (int i = 0; i < 9; i++) begin
            r_en       = tbl[i].en;
            w_ptr_gray = tbl[i].wg;
            tick();
            chk_all($sformatf("vec%0d", i), tbl[i].empty, tbl[i].ae, tbl[i].lvl,
                    tbl[i].addr, tbl[i].pg, tbl[i].valid, tbl[i].uf);
        end

        // Fill to 8 then drain with wrap-around
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            w_ptr_gray = g4(i);
            tick();
        end
        repeat (3) tick();
        chk("full.level", 32'(r_level), 32'd8);
        chk("full.empty", 32'(r_empty), 32'd0);
        chk("full.ae",    32'(r_almost_empty), 32'd0);
        r_en = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk($sformatf("drain%0d.addr", i),  32'(r_addr), 32'(i % 8));
            chk($sformatf("drain%0d.level", i), 32'(r_level), 32'(8 - i));
            chk($sformatf("drain%0d.ae", i),    32'(r_almost_empty), 32'((8 - i) <= 1));
            chk($sformatf("drain%0d.empty", i), 32'(r_empty), 32'(i == 8));
        end
        r_en = 1'b0;
        chk("drain.pgray", 32'(r_ptr_gray), 32'b1100);

        // Write lands while the last entry is read
        w_ptr_gray = g4(9);
        repeat (3) tick();
        chk("conc.pre_level", 32'(r_level), 32'd1);
        r_en       = 1'b1;
        w_ptr_gray = g4(10);
        tick();
        r_en = 1'b0;
        chk("conc.e1.empty", 32'(r_empty), 32'd1);
        chk("conc.e1.valid", 32'(r_valid), 32'd1);
        tick();
        chk("conc.e2.empty", 32'(r_empty), 32'd1);
        tick();
        chk("conc.e3.empty", 32'(r_empty), 32'd0);
        chk("conc.e3.level", 32'(r_level), 32'd1);
        chk("conc.uflow",    32'(r_underflow), 32'd0);

        // Async reset mid-drain
        w_ptr_gray = g4(11);
        tick();
        w_ptr_gray = g4(12);
        repeat (3) tick();
        chk("mid.level", 32'(r_level), 32'd3);
        r_en = 1'b1;
        tick();
        #2;
        r_rst_n    = 1'b0;
        w_ptr_gray = 4'd0;
        #1;
        chk_all("async_rst", 1'b1, 1'b1, 4'd0, 3'd0, 4'd0, 1'b0, 1'b0);
        #2;
        r_rst_n    = 1'b1;
        w_ptr_gray = g4(1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("post_rst%0d.addr", i),  32'(r_addr), 32'd0);
            chk($sformatf("post_rst%0d.valid", i), 32'(r_valid), 32'd0);
        end
        chk("post_rst.empty", 32'(r_empty), 32'd0);
        tick();
        chk("post_rst.addr", 32'(r_addr), 32'd1);
        chk("post_rst.valid", 32'(r_valid), 32'd1);
        r_en = 1'b0;

        // Randomized traffic against the counting model
        do_reset();
        model_reset();
        for (int c = 0; c < 600; c++) begin
            r_en = 1'($urandom_range(0, 1));
            if ((m_w - m_rd) < 8 && $urandom_range(0, 2) != 0) m_w++;
            w_ptr_gray = g4(m_w);
            @(posedge r_clk);
            seen = m_seen_q.pop_front();
            m_seen_q.push_back(m_w);
            acc = r_en && !m_empty;
            if (r_en && m_empty) m_uf = 1;
            if (acc) m_rd++;
            lvl = seen - m_rd;
            m_empty = (lvl == 0);
            #1;
            chk_all($sformatf("rnd%0d", c), m_empty, lvl <= 1, 4'(lvl), 3'(m_rd % 8),
                    g4(m_rd), acc, 1'(m_uf));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
